// File: rtl/unidade_controle.sv
// Multi-cycle control unit for the 8-bit processor: sequences fetch, decode, execute,
// memory and write-back, and counts retired instructions.
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] instrucao,
    input  logic       zero,
    input  logic       mem_pronto,
    output logic [2:0] sinal_ula,
    output logic       sel_ula_a,
    output logic [1:0] sel_ula_b,
    output logic       sel_endereco,
    output logic       sel_pc,
    output logic       sel_dado_reg,
    output logic       mem_req,
    output logic       mem_escreve,
    output logic       ir_escreve,
    output logic       pc_escreve,
    output logic       reg_escreve,
    output logic       parado,
    output logic [7:0] instr_concluidas
);

    typedef enum logic [3:0] {
        StBusca,
        StDecodifica,
        StExecR,
        StEscritaR,
        StCalcEnd,
        StAcessoMem,
        StEscritaMem,
        StDesvio,
        StParada
    } estado_t;

    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;
    localparam logic [2:0] OpLw  = 3'b101;
    localparam logic [2:0] OpSw  = 3'b110;
    localparam logic [2:0] OpExt = 3'b111;

    estado_t    state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       retire;

    logic [2:0] opcode;
    logic       is_lw, is_sw, is_halt, is_beq;

    assign opcode  = instrucao[7:5];
    assign is_lw   = (opcode == OpLw);
    assign is_sw   = (opcode == OpSw);
    assign is_halt = (opcode == OpExt) && (instrucao[4:0] == 5'b00000);
    assign is_beq  = (opcode == OpExt) && (instrucao[4:0] != 5'b00000);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StBusca;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        sinal_ula    = 3'b000;
        sel_ula_a    = 1'b0;
        sel_ula_b    = 2'b00;
        sel_endereco = 1'b0;
        sel_pc       = 1'b0;
        sel_dado_reg = 1'b0;
        mem_req      = 1'b0;
        mem_escreve  = 1'b0;
        ir_escreve   = 1'b0;
        pc_escreve   = 1'b0;
        reg_escreve  = 1'b0;
        parado       = 1'b0;

        case (state_q)
            StBusca: begin
                mem_req    = 1'b1;
                sel_ula_b  = 2'b01;
                sinal_ula  = OpAdd;
                ir_escreve = mem_pronto;
                pc_escreve = mem_pronto;
                if (mem_pronto) begin
                    state_d = StDecodifica;
                end
            end
            StDecodifica: begin
                // Branch target PC + imm is computed here and latched by the datapath
                sel_ula_b = 2'b10;
                sinal_ula = OpAdd;
                if (is_halt) begin
                    state_d = StParada;
                end else if (is_beq) begin
                    state_d = StDesvio;
                end else if (is_lw || is_sw) begin
                    state_d = StCalcEnd;
                end else begin
                    state_d = StExecR;
                end
            end
            StExecR: begin
                sel_ula_a = 1'b1;
                sinal_ula = opcode;
                state_d   = StEscritaR;
            end
            StEscritaR: begin
                reg_escreve = 1'b1;
                retire      = 1'b1;
                state_d     = StBusca;
            end
            StCalcEnd: begin
                sel_ula_a = 1'b1;
                sel_ula_b = 2'b10;
                sinal_ula = OpAdd;
                state_d   = StAcessoMem;
            end
            StAcessoMem: begin
                mem_req      = 1'b1;
                sel_endereco = 1'b1;
                mem_escreve  = is_sw;
                if (mem_pronto) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = StBusca;
                    end else begin
                        state_d = StEscritaMem;
                    end
                end
            end
            StEscritaMem: begin
                reg_escreve  = 1'b1;
                sel_dado_reg = 1'b1;
                retire       = 1'b1;
                state_d      = StBusca;
            end
            StDesvio: begin
                sel_ula_a  = 1'b1;
                sinal_ula  = OpSub;
                sel_pc     = 1'b1;
                pc_escreve = zero;
                retire     = 1'b1;
                state_d    = StBusca;
            end
            StParada: begin
                parado = 1'b1;
            end
            default: begin
                state_d = StBusca;
            end
        endcase

        // Reset is asynchronous, so outputs are gated combinationally while it is low
        if (!reset) begin
            state_d      = StBusca;
            retire       = 1'b0;
            sinal_ula    = 3'b000;
            sel_ula_a    = 1'b0;
            sel_ula_b    = 2'b00;
            sel_endereco = 1'b0;
            sel_pc       = 1'b0;
            sel_dado_reg = 1'b0;
            mem_req      = 1'b0;
            mem_escreve  = 1'b0;
            ir_escreve   = 1'b0;
            pc_escreve   = 1'b0;
            reg_escreve  = 1'b0;
            parado       = 1'b0;
        end
    end

    always_comb begin
        count_d = retire ? count_q + 8'd1 : count_q;
    end

    assign instr_concluidas = count_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: per-cycle expected output vectors are queued
// as stimulus is applied and compared when the cycle's outputs are sampled.
module tb_unidade_controle;

    logic       clock;
    logic       reset;
    logic [7:0] instrucao;
    logic       zero;
    logic       mem_pronto;
    logic [2:0] sinal_ula;
    logic       sel_ula_a;
    logic [1:0] sel_ula_b;
    logic       sel_endereco;
    logic       sel_pc;
    logic       sel_dado_reg;
    logic       mem_req;
    logic       mem_escreve;
    logic       ir_escreve;
    logic       pc_escreve;
    logic       reg_escreve;
    logic       parado;
    logic [7:0] instr_concluidas;

    logic [14:0] obs;

    typedef struct packed {
        logic [14:0] v;
        logic [7:0]  c;
    } exp_t;

    typedef struct packed {
        logic [7:0]  i;
        logic        z;
        logic        p;
        logic [14:0] v;
        logic [7:0]  c;
    } step_t;

    exp_t       sb[$];
    int         checks;
    int         errors;
    logic [7:0] cnt_m;

    unidade_controle dut (
        .clock            (clock),
        .reset            (reset),
        .instrucao        (instrucao),
        .zero             (zero),
        .mem_pronto       (mem_pronto),
        .sinal_ula        (sinal_ula),
        .sel_ula_a        (sel_ula_a),
        .sel_ula_b        (sel_ula_b),
        .sel_endereco     (sel_endereco),
        .sel_pc           (sel_pc),
        .sel_dado_reg     (sel_dado_reg),
        .mem_req          (mem_req),
        .mem_escreve      (mem_escreve),
        .ir_escreve       (ir_escreve),
        .pc_escreve       (pc_escreve),
        .reg_escreve      (reg_escreve),
        .parado           (parado),
        .instr_concluidas (instr_concluidas)
    );

    assign obs = {sinal_ula, sel_ula_a, sel_ula_b, sel_endereco, sel_pc, sel_dado_reg,
                  mem_req, mem_escreve, ir_escreve, pc_escreve, reg_escreve, parado};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    // Expected output vectors per state, laid out like obs
    function automatic logic [14:0] exp_busca(input logic p);
        return {3'b010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, p, p, 1'b0, 1'b0};
    endfunction
    function automatic logic [14:0] exp_dec();
        return {3'b010, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [14:0] exp_execr(input logic [2:0] op);
        return {op, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [14:0] exp_escr();
        return {3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic logic [14:0] exp_calc();
        return {3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [14:0] exp_acesso(input logic w);
        return {3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [14:0] exp_escm();
        return {3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic logic [14:0] exp_desvio(input logic z);
        return {3'b011, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, 1'b0};
    endfunction
    function automatic logic [14:0] exp_parada();
        return 15'h0001;
    endfunction

    function automatic step_t mk(input logic [7:0] i, input logic z, input logic p,
                                 input logic [14:0] v, input logic [7:0] c);
        step_t s;
        s.i = i;
        s.z = z;
        s.p = p;
        s.v = v;
        s.c = c;
        return s;
    endfunction

    task automatic drive(input logic [7:0] i, input logic z, input logic p);
        @(posedge clock);
        #1;
        instrucao  = i;
        zero       = z;
        mem_pronto = p;
    endtask

    task automatic test_reset();
        exp_t e;
        reset      = 1'b0;
        instrucao  = 8'h00;
        zero       = 1'b0;
        mem_pronto = 1'b0;
        cnt_m      = 8'd0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{15'h0000, 8'd0});
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v || instr_concluidas !== e.c) begin
                errors++;
                $display("FAIL reset_low %0d: got %h cnt %0d, want %h cnt %0d",
                         k, obs, instr_concluidas, e.v, e.c);
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        sb.push_back('{exp_busca(1'b0), 8'd0});
        @(negedge clock);
        e = sb.pop_front();
        checks++;
        if (obs !== e.v || instr_concluidas !== e.c) begin
            errors++;
            $display("FAIL reset_release: got %h cnt %0d, want %h cnt %0d",
                     obs, instr_concluidas, e.v, e.c);
        end
    endtask

    task automatic test_rtype();
        step_t      st[$];
        exp_t       e;
        logic [7:0] ops[5];
        logic [7:0] op;
        ops = '{8'h48, 8'h68, 8'h88, 8'h08, 8'h28};
        for (int k = 0; k < 5; k++) begin
            op = ops[k];
            st.push_back(mk(op, 1'b0, 1'b1, exp_busca(1'b1), cnt_m));
            st.push_back(mk(op, 1'b1, 1'b0, exp_dec(), cnt_m));
            st.push_back(mk(op, 1'b1, 1'b1, exp_execr(op[7:5]), cnt_m));
            st.push_back(mk(op, 1'b0, 1'b1, exp_escr(), cnt_m));
            cnt_m = cnt_m + 8'd1;
        end
        foreach (st[k]) begin
            drive(st[k].i, st[k].z, st[k].p);
            sb.push_back('{st[k].v, st[k].c});
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v || instr_concluidas !== e.c) begin
                errors++;
                $display("FAIL rtype step %0d: got %h cnt %0d, want %h cnt %0d",
                         k, obs, instr_concluidas, e.v, e.c);
            end
        end
    endtask

    task automatic test_lw();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(8'hA1, 1'b0, 1'b0, exp_busca(1'b0), cnt_m));
        st.push_back(mk(8'hA1, 1'b0, 1'b0, exp_busca(1'b0), cnt_m));
        st.push_back(mk(8'hA1, 1'b0, 1'b1, exp_busca(1'b1), cnt_m));
        st.push_back(mk(8'hA1, 1'b0, 1'b0, exp_dec(), cnt_m));
        st.push_back(mk(8'hA1, 1'b0, 1'b0, exp_calc(), cnt_m));
        for (int k = 0; k < 3; k++) begin
            st.push_back(mk(8'hA1, 1'b0, 1'b0, exp_acesso(1'b0), cnt_m));
        end
        st.push_back(mk(8'hA1, 1'b0, 1'b1, exp_acesso(1'b0), cnt_m));
        st.push_back(mk(8'hA1, 1'b0, 1'b1, exp_escm(), cnt_m));
        cnt_m = cnt_m + 8'd1;
        st.push_back(mk(8'hA1, 1'b0, 1'b0, exp_busca(1'b0), cnt_m));
        foreach (st[k]) begin
            drive(st[k].i, st[k].z, st[k].p);
            sb.push_back('{st[k].v, st[k].c});
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v || instr_concluidas !== e.c) begin
                errors++;
                $display("FAIL lw step %0d: got %h cnt %0d, want %h cnt %0d",
                         k, obs, instr_concluidas, e.v, e.c);
            end
        end
    endtask

    task automatic test_beq();
        step_t st[$];
        exp_t  e;
        logic  z;
        for (int k = 0; k < 2; k++) begin
            z = (k == 0);
            st.push_back(mk(8'hE3, ~z, 1'b1, exp_busca(1'b1), cnt_m));
            st.push_back(mk(8'hE3, ~z, 1'b0, exp_dec(), cnt_m));
            st.push_back(mk(8'hE3, z, 1'b0, exp_desvio(z), cnt_m));
            cnt_m = cnt_m + 8'd1;
        end
        foreach (st[k]) begin
            drive(st[k].i, st[k].z, st[k].p);
            sb.push_back('{st[k].v, st[k].c});
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v || instr_concluidas !== e.c) begin
                errors++;
                $display("FAIL beq step %0d: got %h cnt %0d, want %h cnt %0d",
                         k, obs, instr_concluidas, e.v, e.c);
            end
        end
    endtask

    task automatic test_sw();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(8'hC2, 1'b0, 1'b1, exp_busca(1'b1), cnt_m));
        st.push_back(mk(8'hC2, 1'b0, 1'b1, exp_dec(), cnt_m));
        st.push_back(mk(8'hC2, 1'b0, 1'b1, exp_calc(), cnt_m));
        st.push_back(mk(8'hC2, 1'b0, 1'b1, exp_acesso(1'b1), cnt_m));
        cnt_m = cnt_m + 8'd1;
        st.push_back(mk(8'hC2, 1'b0, 1'b0, exp_busca(1'b0), cnt_m));
        foreach (st[k]) begin
            drive(st[k].i, st[k].z, st[k].p);
            sb.push_back('{st[k].v, st[k].c});
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v || instr_concluidas !== e.c) begin
                errors++;
                $display("FAIL sw step %0d: got %h cnt %0d, want %h cnt %0d",
                         k, obs, instr_concluidas, e.v, e.c);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        exp_t  e;
        for (int n = 0; n < 256; n++) begin
            st.push_back(mk(8'hC2, 1'b0, 1'b1, exp_busca(1'b1), cnt_m));
            st.push_back(mk(8'hC2, 1'b0, 1'b1, exp_dec(), cnt_m));
            st.push_back(mk(8'hC2, 1'b0, 1'b1, exp_calc(), cnt_m));
            st.push_back(mk(8'hC2, 1'b0, 1'b1, exp_acesso(1'b1), cnt_m));
            cnt_m = cnt_m + 8'd1;
        end
        st.push_back(mk(8'hC2, 1'b0, 1'b0, exp_busca(1'b0), cnt_m));
        foreach (st[k]) begin
            drive(st[k].i, st[k].z, st[k].p);
            sb.push_back('{st[k].v, st[k].c});
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v || instr_concluidas !== e.c) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %h cnt %0d, want %h cnt %0d",
                         k, obs, instr_concluidas, e.v, e.c);
            end
        end
    endtask

    task automatic test_halt();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(8'hE0, 1'b0, 1'b1, exp_busca(1'b1), cnt_m));
        st.push_back(mk(8'hE0, 1'b0, 1'b0, exp_dec(), cnt_m));
        for (int k = 0; k < 20; k++) begin
            st.push_back(mk(8'hE0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            exp_parada(), cnt_m));
        end
        foreach (st[k]) begin
            drive(st[k].i, st[k].z, st[k].p);
            sb.push_back('{st[k].v, st[k].c});
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v || instr_concluidas !== e.c) begin
                errors++;
                $display("FAIL halt step %0d: got %h cnt %0d, want %h cnt %0d",
                         k, obs, instr_concluidas, e.v, e.c);
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 15'h0000 || instr_concluidas !== 8'd0) begin
            errors++;
            $display("FAIL halt_reset_low: got %h cnt %0d, want 0000 cnt 0",
                     obs, instr_concluidas);
        end
        @(posedge clock);
        #1;
        reset      = 1'b1;
        mem_pronto = 1'b0;
        zero       = 1'b0;
        cnt_m      = 8'd0;
        sb.push_back('{exp_busca(1'b0), cnt_m});
        @(negedge clock);
        e = sb.pop_front();
        checks++;
        if (obs !== e.v || instr_concluidas !== e.c) begin
            errors++;
            $display("FAIL halt_restart: got %h cnt %0d, want %h cnt %0d",
                     obs, instr_concluidas, e.v, e.c);
        end
    endtask

    task automatic test_reset_mid();
        step_t st[$];
        step_t rs[$];
        exp_t  e;
        st.push_back(mk(8'h48, 1'b0, 1'b1, exp_busca(1'b1), cnt_m));
        st.push_back(mk(8'h48, 1'b0, 1'b0, exp_dec(), cnt_m));
        foreach (st[k]) begin
            drive(st[k].i, st[k].z, st[k].p);
            sb.push_back('{st[k].v, st[k].c});
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v || instr_concluidas !== e.c) begin
                errors++;
                $display("FAIL reset_mid pre step %0d: got %h cnt %0d, want %h cnt %0d",
                         k, obs, instr_concluidas, e.v, e.c);
            end
        end
        // Now in EXEC_R; assert reset between edges
        drive(8'h48, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 15'h0000 || instr_concluidas !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h cnt %0d, want 0000 cnt 0",
                     obs, instr_concluidas);
        end
        @(posedge clock);
        #1;
        reset      = 1'b1;
        mem_pronto = 1'b0;
        cnt_m      = 8'd0;
        rs.push_back(mk(8'h48, 1'b0, 1'b0, exp_busca(1'b0), cnt_m));
        rs.push_back(mk(8'h48, 1'b0, 1'b1, exp_busca(1'b1), cnt_m));
        rs.push_back(mk(8'h48, 1'b0, 1'b0, exp_dec(), cnt_m));
        rs.push_back(mk(8'h48, 1'b0, 1'b0, exp_execr(3'b010), cnt_m));
        rs.push_back(mk(8'h48, 1'b0, 1'b0, exp_escr(), cnt_m));
        cnt_m = cnt_m + 8'd1;
        rs.push_back(mk(8'h48, 1'b0, 1'b0, exp_busca(1'b0), cnt_m));
        sb.push_back('{rs[0].v, rs[0].c});
        @(negedge clock);
        e = sb.pop_front();
        checks++;
        if (obs !== e.v || instr_concluidas !== e.c) begin
            errors++;
            $display("FAIL reset_mid_release: got %h cnt %0d, want %h cnt %0d",
                     obs, instr_concluidas, e.v, e.c);
        end
        for (int k = 1; k < rs.size(); k++) begin
            drive(rs[k].i, rs[k].z, rs[k].p);
            sb.push_back('{rs[k].v, rs[k].c});
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v || instr_concluidas !== e.c) begin
                errors++;
                $display("FAIL reset_mid post step %0d: got %h cnt %0d, want %h cnt %0d",
                         k, obs, instr_concluidas, e.v, e.c);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rtype();
        test_lw();
        test_beq();
        test_sw();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit for the 8-bit processor: the FSM that drives the ALU's `sinal_ula` select and consumes its `zero` flag. It sequences fetch, decode, execute, memory and write-back for every instruction. It handshakes with instruction/data memory through `mem_req`/`mem_pronto`. It sits between the instruction register and the datapath muxes, register file, PC and ALU.

## Interface
- No parameters. Opcode map and state encoding are fixed.
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low. Low means state = BUSCA, counter = 0, and all write/request strobes forced to 0 while low.
- `instrucao`  in  8  IR contents. Bits [7:5] are the opcode; [4:0] are fields (halt detect only).
- `zero`  in  1  ALU zero flag.
- `mem_pronto`  in  1  memory completes the current request this cycle.
- `sinal_ula`  out  3  ALU op: 000 and, 001 or, 010 add, 011 sub, 100 slt.
- `sel_ula_a`  out  1  0 = PC, 1 = register A.
- `sel_ula_b`  out  2  00 = register B, 01 = constant 1, 10 = sign-extended imm[2:0], 11 unused.
- `sel_endereco`  out  1  memory address: 0 = PC, 1 = registered ALU output.
- `sel_pc`  out  1  PC source: 0 = live ALU output, 1 = registered ALU output.
- `sel_dado_reg`  out  1  register write data: 0 = registered ALU output, 1 = memory data.
- `mem_req`, `mem_escreve`, `ir_escreve`, `pc_escreve`, `reg_escreve`  out  1 each  strobes.
- `parado`  out  1  high in PARADA.
- `instr_concluidas`  out  8  retired-instruction counter.

## Operation
- Opcodes:
  - 000–100: R-type. ALU op = opcode.
  - 101: LW.
  - 110: SW.
  - 111 with [4:0]=00000: HALT.
  - 111 otherwise: BEQ.
- Outputs are Moore-decoded from the state, plus `instrucao`, `zero` and `mem_pronto` where noted. Unlisted strobes are 0. `sinal_ula` is 000 where not listed.
- BUSCA:
  - Drives `mem_req`=1, `sel_endereco`=0, `sel_ula_a`=0, `sel_ula_b`=01, `sinal_ula`=010, `sel_pc`=0.
  - `ir_escreve` = `pc_escreve` = `mem_pronto`.
  - Next state: DECODIFICA if `mem_pronto`, else stay.
- DECODIFICA:
  - Drives `sel_ula_a`=0, `sel_ula_b`=10, `sinal_ula`=010. This computes the branch target, which the datapath registers.
  - Next state: R-type → EXEC_R; LW/SW → CALC_END; BEQ → DESVIO; HALT → PARADA.
- EXEC_R: drives `sel_ula_a`=1, `sel_ula_b`=00, `sinal_ula`=`instrucao[7:5]`. Next state: ESCRITA_R.
- ESCRITA_R: drives `reg_escreve`=1, `sel_dado_reg`=0. Next state: BUSCA.
- CALC_END: drives `sel_ula_a`=1, `sel_ula_b`=10, `sinal_ula`=010. Next state: ACESSO_MEM.
- ACESSO_MEM:
  - Drives `mem_req`=1, `sel_endereco`=1, `mem_escreve` = (opcode==110).
  - Waits for `mem_pronto`. Then SW → BUSCA; LW → ESCRITA_MEM.
- ESCRITA_MEM: drives `reg_escreve`=1, `sel_dado_reg`=1. Next state: BUSCA.
- DESVIO:
  - Drives `sel_ula_a`=1, `sel_ula_b`=00, `sinal_ula`=011, `sel_pc`=1.
  - `pc_escreve` = `zero`.
  - Next state: BUSCA.
- PARADA: `parado`=1, all strobes 0. Leaves only through `reset`.
- `instr_concluidas` increments by 1 on each transition into BUSCA from ESCRITA_R, ESCRITA_MEM, ACESSO_MEM(SW) or DESVIO.
  - Wraps 255 → 0.
  - HALT does not count.
- `instrucao` changes outside BUSCA have no effect on the state sequence other than the decode listed above. The IR is stable by design.

## Timing
- Reset values:
  - While reset is low: state BUSCA, `instr_concluidas`=0, `parado`=0, every strobe 0.
  - After release: BUSCA outputs, i.e. `mem_req`=1 from the first cycle.
- Latency with `mem_pronto` high on first request: R-type 4 cycles, LW 5, SW 4, BEQ 3, HALT 2 then PARADA forever.
- Each cycle with `mem_pronto` low in BUSCA/ACESSO_MEM adds one cycle. `mem_req` stays high and the address select stays stable throughout.
- Reset asserted mid-instruction aborts immediately, with no partial strobe after assertion. Counter clears.
- `pc_escreve` in DESVIO follows `zero` in that same cycle.

## Test plan
- Reset, then IR=0x48 (ADD), `mem_pronto`=1 → states BUSCA, DECODIFICA, EXEC_R (`sinal_ula`=010), ESCRITA_R (`reg_escreve`=1); counter 0→1 at cycle 4.
- LW (0xA1) with `mem_pronto` low 3 cycles in ACESSO_MEM → `mem_req`=1, `sel_endereco`=1, `mem_escreve`=0 held 4 cycles; ESCRITA_MEM asserts `sel_dado_reg`=1; total 8 cycles.
- BEQ 0xE3: with `zero`=1 → DESVIO `pc_escreve`=1, `sel_pc`=1, `sinal_ula`=011; with `zero`=0 → `pc_escreve`=0; counter increments both times.
- SW 0xC2 → `mem_escreve`=1 only in ACESSO_MEM, no `reg_escreve`, returns to BUSCA after 4 cycles.
- HALT 0xE0 → `parado`=1 from cycle 3, all strobes 0 for 20 cycles, counter unchanged; a reset pulse restarts in BUSCA with counter 0.
- 256 back-to-back SW instructions → counter wraps to 0. Reset asserted in EXEC_R → strobes 0 asynchronously, BUSCA after release.
